// File: rtl/operand_read.sv
// operand_read: resolves source operands (PC, forwarding, register file), issues
// load requests with an optional timeout and holds one result for execute.
module operand_read #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_COUNT     = 16,
  parameter int PC_REG        = 15,
  parameter int FWD_PORTS     = 2,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [REG_COUNT*DATA_WIDTH-1:0]               registers,
  input  logic                                          in_valid,
  output logic                                          in_hold,
  input  logic                                          in_flush,
  input  logic [DATA_WIDTH-1:0]                         in_pc,
  input  logic [$clog2(REG_COUNT)-1:0]                  in_left_reg,
  input  logic [$clog2(REG_COUNT)-1:0]                  in_right_reg,
  input  logic [$clog2(REG_COUNT)-1:0]                  in_addr_reg,
  input  logic [DATA_WIDTH-1:0]                         in_adjust,
  input  logic                                          in_is_load,
  input  logic                                          in_is_store,
  input  logic [PAYLOAD_WIDTH-1:0]                      in_payload,
  input  logic [FWD_PORTS-1:0]                          fwd_valid,
  input  logic [FWD_PORTS*$clog2(REG_COUNT)-1:0]        fwd_reg,
  input  logic [FWD_PORTS*DATA_WIDTH-1:0]               fwd_value,
  output logic                                          mem_req,
  output logic [DATA_WIDTH-1:0]                         mem_addr,
  input  logic                                          mem_valid,
  input  logic [DATA_WIDTH-1:0]                         mem_data,
  output logic                                          out_valid,
  input  logic                                          out_hold,
  output logic [DATA_WIDTH-1:0]                         out_pc,
  output logic [DATA_WIDTH-1:0]                         out_left,
  output logic [DATA_WIDTH-1:0]                         out_right,
  output logic [DATA_WIDTH-1:0]                         out_adjust,
  output logic [PAYLOAD_WIDTH-1:0]                      out_payload,
  output logic                                          out_fault
);
  localparam int W  = DATA_WIDTH;
  localparam int R  = REG_COUNT;
  localparam int AW = $clog2(REG_COUNT);
  localparam int F  = FWD_PORTS;
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL} state_t;
  // PC beats forwarding; among forwarding ports the lowest index (youngest) wins.
  function automatic logic [W-1:0] resolve(input logic [AW-1:0] k, input logic [W-1:0] pc,
                                           input logic [R*W-1:0] rf, input logic [F-1:0] fv,
                                           input logic [F*AW-1:0] fr, input logic [F*W-1:0] fd);
    resolve = rf[int'(k)*W +: W];
    for (int j = F - 1; j >= 0; j--)
      if (fv[j] && fr[j*AW +: AW] == k) resolve = fd[j*W +: W];
    if (k == AW'(PC_REG)) resolve = pc;
  endfunction
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [W-1:0]           r_pc, r_left, r_right, r_adjust;
  logic [PAYLOAD_WIDTH-1:0] r_payload;
  logic                   r_fault;
  logic [W-1:0]           w_left, w_right, w_addr, w_cap_right, w_cap_adjust;
  logic                   w_issue, w_issue_load, w_timeout, w_wait_done, w_capture;
  assign w_left       = resolve(in_left_reg, in_pc, registers, fwd_valid, fwd_reg, fwd_value);
  assign w_right      = resolve(in_right_reg, in_pc, registers, fwd_valid, fwd_reg, fwd_value);
  assign w_addr       = resolve(in_addr_reg, in_pc, registers, fwd_valid, fwd_reg, fwd_value);
  assign w_issue      = in_valid && !in_flush && (r_state == S_IDLE || (r_state == S_FULL && !out_hold));
  assign w_issue_load = w_issue && in_is_load;
  assign w_timeout    = (MEM_TIMEOUT != 0) && (r_cnt == CW'(MEM_TIMEOUT));
  assign w_wait_done  = r_state == S_WAIT && (mem_valid || w_timeout);
  assign w_capture    = (w_issue && (!in_is_load || mem_valid)) || w_wait_done;
  assign w_cap_right  = r_state == S_WAIT ? (mem_valid ? mem_data : '0) : in_is_load ? mem_data : w_right;
  assign w_cap_adjust = in_is_load && in_is_store ? w_right : in_adjust;
  // The completing WAIT cycle releases upstream so the instruction is consumed exactly once.
  assign in_hold   = in_valid && !in_flush && (r_state == S_WAIT ? !w_wait_done :
                     (r_state == S_FULL && out_hold) || (w_issue_load && !mem_valid));
  assign mem_req   = w_issue_load || r_state == S_WAIT;
  assign mem_addr  = w_addr + in_adjust;
  assign out_valid = r_state == S_FULL;
  assign out_pc      = r_pc;
  assign out_left    = r_left;
  assign out_right   = r_right;
  assign out_adjust  = r_adjust;
  assign out_payload = r_payload;
  assign out_fault   = r_fault;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pc      <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_adjust  <= '0;
      r_payload <= '0;
      r_fault   <= 1'b0;
    end else if (in_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_state   <= S_FULL;
      r_cnt     <= '0;
      r_pc      <= in_pc;
      r_left    <= w_left;
      r_right   <= w_cap_right;
      r_adjust  <= w_cap_adjust;
      r_payload <= in_payload;
      r_fault   <= r_state == S_WAIT && !mem_valid;
    end else if (w_issue_load) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == S_FULL && !out_hold) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_operand_read.sv
// tb_operand_read: scenario tasks with randomized back-to-back traffic checked
// against an operand-resolution model.
module tb_operand_read;
  localparam int W = 32, R = 16, AW = 4, F = 2, P = 16, TO = 4;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, in_valid, in_hold, in_flush, in_is_load, in_is_store;
  logic [R*W-1:0] registers;
  logic [W-1:0] in_pc, in_adjust, mem_addr, mem_data, out_pc, out_left, out_right, out_adjust;
  logic [AW-1:0] in_left_reg, in_right_reg, in_addr_reg;
  logic [P-1:0] in_payload, out_payload;
  logic [F-1:0] fwd_valid;
  logic [F*AW-1:0] fwd_reg;
  logic [F*W-1:0] fwd_value;
  logic mem_req, mem_valid, out_valid, out_hold, out_fault;
  logic [W-1:0] rf[R];
  logic [AW-1:0] fr[F];
  logic [W-1:0] fd[F];
  int errors = 0, checks = 0;
  always_comb begin
    for (int i = 0; i < R; i++) registers[i*W +: W] = rf[i];
    for (int j = 0; j < F; j++) begin
      fwd_reg[j*AW +: AW] = fr[j];
      fwd_value[j*W +: W] = fd[j];
    end
  end
  operand_read #(.DATA_WIDTH(W), .REG_COUNT(R), .PC_REG(15), .FWD_PORTS(F),
                 .PAYLOAD_WIDTH(P), .MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .registers(registers), .in_valid(in_valid), .in_hold(in_hold),
    .in_flush(in_flush), .in_pc(in_pc), .in_left_reg(in_left_reg), .in_right_reg(in_right_reg),
    .in_addr_reg(in_addr_reg), .in_adjust(in_adjust), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_payload(in_payload), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_value(fwd_value), .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .out_valid(out_valid), .out_hold(out_hold), .out_pc(out_pc),
    .out_left(out_left), .out_right(out_right), .out_adjust(out_adjust),
    .out_payload(out_payload), .out_fault(out_fault));
  function automatic logic [W-1:0] model_val(input int k);
    if (k == 15) return in_pc;
    for (int j = 0; j < F; j++) if (fwd_valid[j] && int'(fr[j]) == k) return fd[j];
    return rf[k];
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    in_valid = 0; in_flush = 0; in_is_load = 0; in_is_store = 0;
    mem_valid = 0; out_hold = 0; fwd_valid = '0;
  endtask
  task automatic set_instr(input int l, input int r, input int a, input logic ld, input logic st);
    in_valid = 1; in_left_reg = AW'(l); in_right_reg = AW'(r); in_addr_reg = AW'(a);
    in_is_load = ld; in_is_store = st; in_pc = $urandom; in_adjust = $urandom;
    in_payload = P'($urandom);
  endtask
  task automatic test_reset;
    reset = 1; idle; in_pc = 0; in_adjust = 0; in_payload = 0; mem_data = 0;
    in_left_reg = 0; in_right_reg = 0; in_addr_reg = 0;
    for (int i = 0; i < R; i++) rf[i] = $urandom;
    for (int j = 0; j < F; j++) begin fr[j] = 0; fd[j] = 0; end
    repeat (3) tick;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", out_fault); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if ({out_pc, out_left, out_right, out_adjust, out_payload} !== '0) begin errors++;
      $display("FAIL reset_data got=%h %h %h %h %h exp=0", out_pc, out_left, out_right, out_adjust, out_payload); end
    @(posedge clock); #1 reset = 0;
  endtask
  task automatic test_add;
    logic [W-1:0] e_pc, e_adj;
    logic [P-1:0] e_pl;
    rf[3] = 5; rf[4] = 7;
    set_instr(3, 4, 0, 0, 0);
    e_pc = in_pc; e_adj = in_adjust; e_pl = in_payload;
    @(negedge clock);
    checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL add_hold got=%b exp=0", in_hold); end
    tick; idle;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (out_left !== 32'd5) begin errors++; $display("FAIL add_left got=%h exp=5", out_left); end
    checks++; if (out_right !== 32'd7) begin errors++; $display("FAIL add_right got=%h exp=7", out_right); end
    checks++; if ({out_pc, out_adjust, out_payload} !== {e_pc, e_adj, e_pl}) begin errors++;
      $display("FAIL add_pass got=%h %h %h exp=%h %h %h", out_pc, out_adjust, out_payload, e_pc, e_adj, e_pl); end
    tick;
  endtask
  task automatic test_forward;
    logic [W-1:0] e_r;
    rf[3] = 1; fwd_valid = 2'b11; fr[0] = 3; fr[1] = 3; fd[0] = 32'hA; fd[1] = 32'hB;
    set_instr(3, 5, 0, 0, 0);
    e_r = rf[5];
    tick; idle;
    @(negedge clock);
    checks++; if (out_left !== 32'hA) begin errors++; $display("FAIL fwd_youngest got=%h exp=a", out_left); end
    checks++; if (out_right !== e_r) begin errors++; $display("FAIL fwd_nomatch got=%h exp=%h", out_right, e_r); end
    set_instr(15, 3, 0, 0, 0);
    in_pc = 32'h100; fwd_valid = 2'b10;
    tick; idle;
    @(negedge clock);
    checks++; if (out_left !== 32'h100) begin errors++; $display("FAIL fwd_pc got=%h exp=100", out_left); end
    checks++; if (out_right !== 32'hB) begin errors++; $display("FAIL fwd_port1 got=%h exp=b", out_right); end
    tick;
  endtask
  task automatic test_back_to_back;
    logic [W-1:0] p_l, p_r, p_a, p_pc, e_addr;
    logic [P-1:0] p_pl;
    logic have = 0, ld, st;
    for (int n = 0; n < 40; n++) begin
      rf[$urandom_range(0, R-1)] = $urandom;
      fwd_valid = F'($urandom);
      for (int j = 0; j < F; j++) begin fr[j] = AW'($urandom); fd[j] = $urandom; end
      ld = ($urandom % 3) == 0; st = 1'($urandom);
      set_instr($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), ld, st);
      mem_valid = ld; mem_data = $urandom;
      e_addr = model_val(int'(in_addr_reg)) + in_adjust;
      @(negedge clock);
      checks++; if (in_hold !== 1'b0) begin errors++; $display("FAIL b2b_hold n=%0d got=%b exp=0", n, in_hold); end
      checks++; if (mem_req !== ld) begin errors++; $display("FAIL b2b_req n=%0d got=%b exp=%b", n, mem_req, ld); end
      if (ld) begin
        checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL b2b_addr n=%0d got=%h exp=%h", n, mem_addr, e_addr); end
      end
      if (have) begin
        checks++; if ({out_valid, out_left, out_right, out_adjust, out_pc, out_payload} !== {1'b1, p_l, p_r, p_a, p_pc, p_pl}) begin
          errors++; $display("FAIL b2b_out n=%0d got=%b %h %h %h %h %h exp=1 %h %h %h %h %h", n, out_valid, out_left,
            out_right, out_adjust, out_pc, out_payload, p_l, p_r, p_a, p_pc, p_pl); end
      end
      p_l = model_val(int'(in_left_reg));
      p_r = ld ? mem_data : model_val(int'(in_right_reg));
      p_a = (ld && st) ? model_val(int'(in_right_reg)) : in_adjust;
      p_pc = in_pc; p_pl = in_payload; have = 1;
      tick;
    end
    idle;
    @(negedge clock);
    checks++; if ({out_valid, out_left, out_right, out_adjust, out_pc} !== {1'b1, p_l, p_r, p_a, p_pc}) begin
      errors++; $display("FAIL b2b_last got=%b %h %h %h %h exp=1 %h %h %h %h", out_valid, out_left, out_right,
        out_adjust, out_pc, p_l, p_r, p_a, p_pc); end
    tick;
  endtask
  task automatic test_load;
    int holds = 0;
    rf[6] = 32'h40; rf[7] = 32'h3;
    set_instr(7, 2, 6, 1, 0);
    in_adjust = 4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (in_hold) holds++;
      if (c == 0) begin
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin errors++; $display("FAIL load_req got=%b %h exp=1 44", mem_req, mem_addr); end
      end
      if (c == 1) begin
        checks++; if ({out_valid, mem_req} !== 2'b01) begin errors++; $display("FAIL load_wait got=%b%b exp=01", out_valid, mem_req); end
      end
      tick;
    end
    fwd_valid = 2'b01; fr[0] = 7; fd[0] = 32'h77; mem_valid = 1; mem_data = 32'hDEAD;
    @(negedge clock);
    checks++; if (holds !== 3 || in_hold !== 1'b0) begin errors++; $display("FAIL load_hold got=%0d,%b exp=3,0", holds, in_hold); end
    tick; idle;
    @(negedge clock);
    checks++; if ({out_valid, out_fault, mem_req} !== 3'b100) begin errors++; $display("FAIL load_done got=%b%b%b exp=100", out_valid, out_fault, mem_req); end
    checks++; if (out_right !== 32'hDEAD) begin errors++; $display("FAIL load_data got=%h exp=dead", out_right); end
    checks++; if (out_left !== 32'h77) begin errors++; $display("FAIL load_late_fwd got=%h exp=77", out_left); end
    tick;
  endtask
  task automatic test_timeout;
    int n = 0;
    set_instr(1, 2, 3, 1, 0);
    @(negedge clock);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req got=%b exp=1", mem_req); end
    tick;
    in_valid = 0; out_hold = 1;
    @(negedge clock);
    while (out_valid !== 1'b1 && n < 20) begin
      tick; n++;
      @(negedge clock);
    end
    checks++; if (n !== TO + 1) begin errors++; $display("FAIL to_cycles got=%0d exp=%0d", n, TO + 1); end
    checks++; if ({out_fault, mem_req} !== 2'b10) begin errors++; $display("FAIL to_flags got=%b%b exp=10", out_fault, mem_req); end
    checks++; if (out_right !== '0) begin errors++; $display("FAIL to_right got=%h exp=0", out_right); end
    idle; tick; tick;
  endtask
  task automatic test_hold;
    logic [W-1:0] a_l, a_pc, b_l, b_pc;
    set_instr(1, 2, 0, 0, 0);
    a_l = model_val(1); a_pc = in_pc;
    tick;
    set_instr(4, 5, 0, 0, 0);
    b_l = model_val(4); b_pc = in_pc; out_hold = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++; if ({in_hold, out_valid, out_left, out_pc} !== {2'b11, a_l, a_pc}) begin errors++;
        $display("FAIL hold_stable c=%0d got=%b%b %h %h exp=11 %h %h", c, in_hold, out_valid, out_left, out_pc, a_l, a_pc); end
      tick;
    end
    out_hold = 0;
    @(negedge clock);
    checks++; if ({in_hold, out_left} !== {1'b0, a_l}) begin errors++; $display("FAIL hold_release got=%b %h exp=0 %h", in_hold, out_left, a_l); end
    tick; idle;
    @(negedge clock);
    checks++; if ({out_valid, out_left, out_pc} !== {1'b1, b_l, b_pc}) begin errors++;
      $display("FAIL hold_next got=%b %h %h exp=1 %h %h", out_valid, out_left, out_pc, b_l, b_pc); end
    tick;
  endtask
  task automatic test_cx_flush;
    rf[9] = 9;
    set_instr(0, 9, 0, 1, 1);
    @(negedge clock);
    checks++; if (in_hold !== 1'b1) begin errors++; $display("FAIL cx_hold got=%b exp=1", in_hold); end
    tick;
    in_flush = 1;
    tick;
    idle; mem_valid = 1; mem_data = 32'h1234;
    @(negedge clock);
    checks++; if ({mem_req, out_valid} !== 2'b00) begin errors++; $display("FAIL cx_flush got=%b%b exp=00", mem_req, out_valid); end
    tick; mem_valid = 0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cx_late_data got=%b exp=0", out_valid); end
    set_instr(0, 9, 2, 1, 1);
    mem_valid = 1; mem_data = 32'h55;
    tick; idle;
    @(negedge clock);
    checks++; if ({out_valid, out_adjust, out_right} !== {1'b1, 32'd9, 32'h55}) begin errors++;
      $display("FAIL cx_result got=%b %h %h exp=1 9 55", out_valid, out_adjust, out_right); end
    tick;
  endtask
  task automatic test_reset_wait;
    set_instr(0, 1, 2, 1, 0);
    tick;
    in_valid = 0; reset = 1;
    tick;
    reset = 0; mem_valid = 1; mem_data = 32'hBEEF;
    @(negedge clock);
    checks++; if ({mem_req, out_valid} !== 2'b00) begin errors++; $display("FAIL rst_wait got=%b%b exp=00", mem_req, out_valid); end
    tick; mem_valid = 0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ignore got=%b exp=0", out_valid); end
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_add;
    test_forward;
    test_back_to_back;
    test_load;
    test_timeout;
    test_hold;
    test_cx_flush;
    test_reset_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_read.md
OPERAND_READ -- requirements
Module: operand_read

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, register/data width W.
- REG_COUNT, 16, architectural registers R; index width A = clog2(R).
- PC_REG, 15, register index that reads in_pc instead of the register file.
- FWD_PORTS, 2, forwarding sources F; port 0 is youngest.
- PAYLOAD_WIDTH, 16, opaque bits P passed through unchanged.
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_valid; 0 disables the timeout.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- registers, in, R*W, flat register file; entry i at [i*W +: W].
- in_valid, in, 1, upstream instruction valid.
- in_hold, out, 1, upstream stall.
- in_flush, in, 1, kill the current instruction.
- in_pc, in, W, instruction PC.
- in_left_reg, in_right_reg, in_addr_reg, in, A each, source indices.
- in_adjust, in, W, address/adjustment immediate.
- in_is_load, in_is_store, in, 1 each, memory read / write flags; both set = exchange (CX).
- in_payload, in, P, passthrough.
- fwd_valid, in, F, forwarding entry valid.
- fwd_reg, in, F*A, forwarded destination index.
- fwd_value, in, F*W, forwarded value.
- mem_req, out, 1, memory read request.
- mem_addr, out, W, memory read address.
- mem_valid, in, 1, memory data valid.
- mem_data, in, W, memory data.
- out_valid, out, 1, result valid.
- out_hold, in, 1, downstream stall.
- out_pc, out_left, out_right, out_adjust, out, W each, outputs to execute.
- out_payload, out, P, passthrough.
- out_fault, out, 1, memory timeout occurred.

Function
REQ-003 Operand resolution for index k SHALL be combinational, in priority order: k==PC_REG gives in_pc; else the lowest-numbered j with fwd_valid[j] and fwd_reg[j]==k gives fwd_value[j]; else registers[k].
REQ-004 mem_addr SHALL equal resolved(in_addr_reg) + in_adjust, modulo 2^W.
REQ-005 FSM states SHALL be IDLE, WAIT, FULL.
REQ-006 IDLE, in_valid, !in_is_load, !in_flush: capture outputs and go to FULL.
REQ-007 IDLE, in_valid, in_is_load, !in_flush: assert mem_req the same cycle; if mem_valid is also high, capture and go to FULL, else go to WAIT.
REQ-008 WAIT: mem_req SHALL stay high with mem_addr recomputed each cycle. mem_valid captures mem_data into out_right and moves to FULL. A wait counter SHALL increment every WAIT cycle. When the counter reaches MEM_TIMEOUT (if nonzero), the block SHALL capture with out_right=0 and out_fault=1, drop mem_req, and go to FULL.
REQ-009 FULL: out_valid=1 and outputs stable. !out_hold goes to IDLE, or, with an eligible new instruction present, processes it as in REQ-006/007 in the same cycle (back-to-back, one instruction per cycle).
REQ-010 Captured values SHALL be:
- out_pc = in_pc.
- out_left = resolved(in_left_reg).
- out_right = mem data for loads, else resolved(in_right_reg).
- out_adjust = resolved(in_right_reg) when in_is_load && in_is_store, else in_adjust.
- out_payload = in_payload.
- out_fault = 0 unless a timeout occurred.
REQ-011 in_hold SHALL be high when in_valid && (state==WAIT || (state==FULL && out_hold) || a load is issued without mem_valid this cycle).
REQ-012 in_flush SHALL have priority over everything: return to IDLE, clear out_valid and the wait counter, and drop mem_req; data arriving afterwards is ignored.
REQ-013 Upstream inputs SHALL be re-sampled every cycle while stalled; resolved operands are taken from the capture cycle, so forwarding updates during WAIT are honoured.

Reset
REQ-014 While reset is high at a clock edge: state=IDLE, out_valid=0, out_fault=0, wait counter=0, mem_req=0, all data outputs=0.
REQ-015 Reset asserted mid-WAIT SHALL abandon the request; mem_valid in the next cycle SHALL be ignored.

Verification
REQ-016 Add instruction, left=3, right=4, registers[3]=5, registers[4]=7, no forwarding -> out_valid the next cycle with out_left=5, out_right=7.
REQ-017 fwd_valid=2'b11, both fwd_reg=3, values 0xA and 0xB, registers[3]=1 -> out_left=0xA; left=PC_REG with in_pc=0x100 -> out_left=0x100.
REQ-018 Load with addr_reg value 0x40, adjust 4, mem_valid after 3 cycles with data 0xDEAD -> mem_addr=0x44, in_hold high for 3 cycles, out_right=0xDEAD, out_fault=0.
REQ-019 MEM_TIMEOUT=4, mem_valid never asserted -> out_valid after 5 cycles with out_fault=1, out_right=0, mem_req low.
REQ-020 out_hold high for 2 cycles in FULL with a new instruction waiting -> outputs unchanged, in_hold=1; release -> new instruction captured next cycle, none lost.
REQ-021 CX with right register value 9, in_flush during WAIT -> out_valid stays 0, mem_req drops the next cycle; an unflushed CX yields out_adjust=9.
